// File: rtl/uart_arb_pkg.sv
// Shared types and widths for the UART transmit arbiter.
// The state encoding and byte/counter widths live here so the top and the bench agree on them.
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int COUNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN    = 2'd1,
        ST_SETTLE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted valid bit at or above ptr_i, wrapping modulo N.
// Returns the winner as both a one-hot vector and an index.
module rr_priority_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     pick_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default before the loop, so no path leaves a value unassigned and no latch is inferred.
        cand   = 0;
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_i) + k) % N;
            if (!any_o && valid_i[cand]) begin
                any_o        = 1'b1;
                pick_o[cand] = 1'b1;
                idx_o        = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmit path between NUM_REQ byte streams.
// SETTLE_CYCLES must be at least 1; a locked owner that goes quiet is evicted after LOCK_TIMEOUT cycles.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETTLE_CYCLES = 2,
    parameter int LOCK_TIMEOUT  = 270000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      uart_fifo_ready,
    output logic                      start_uart,
    output logic [BYTE_W-1:0]         uart_tx_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      timeout_pulse,
    output logic [COUNT_W-1:0]        byte_count
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TO_W  = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int SC_W  = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic                last_q, last_d;
    logic                start_q, start_d;
    logic [BYTE_W-1:0]   data_q, data_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                tout_q, tout_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [SC_W-1:0]     scnt_q, scnt_d;

    logic [NUM_REQ-1:0]  pick;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic                owner_valid;
    logic                owner_last;
    logic [BYTE_W-1:0]   owner_byte;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    rr_priority_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    assign owner_valid = req_valid[owner_q];
    assign owner_last  = req_last[owner_q];
    assign owner_byte  = req_data[BYTE_W*int'(owner_q) +: BYTE_W];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        start_d   = 1'b0;
        data_d    = data_q;
        count_d   = count_q;
        tout_d    = 1'b0;
        tcnt_d    = tcnt_q;
        scnt_d    = scnt_q;
        req_ready = '0;

        unique case (state_q)
            ST_IDLE: begin
                tcnt_d = '0;
                scnt_d = '0;
                if (pick_any) begin
                    grant_d = pick;
                    owner_d = pick_idx;
                    state_d = ST_OWN;
                end
            end

            ST_OWN: begin
                // Ready follows the UART alone so the owner can see the slot before it raises valid.
                req_ready = grant_q & {NUM_REQ{uart_fifo_ready}};
                if (owner_valid) begin
                    if (uart_fifo_ready) begin
                        start_d = 1'b1;
                        data_d  = owner_byte;
                        count_d = count_q + 1'b1;
                        last_d  = owner_last;
                        tcnt_d  = '0;
                        scnt_d  = '0;
                        state_d = ST_SETTLE;
                    end
                end else if (tcnt_q == TO_W'(LOCK_TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    grant_d = '0;
                    ptr_d   = next_idx(owner_q);
                    tcnt_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (scnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
                    scnt_d = '0;
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = next_idx(owner_q);
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_OWN;
                    end
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments only; the next-state logic above is the blocking side.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            tout_q  <= 1'b0;
            tcnt_q  <= '0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            last_q  <= last_d;
            start_q <= start_d;
            data_q  <= data_d;
            count_q <= count_d;
            tout_q  <= tout_d;
            tcnt_q  <= tcnt_d;
            scnt_q  <= scnt_d;
        end
    end

    assign start_uart    = start_q;
    assign uart_tx_data  = data_q;
    assign grant         = grant_q;
    assign timeout_pulse = tout_q;
    assign byte_count    = count_q;

endmodule
